// File: rtl/io_port_bank.sv
// ============================================================================
// io_port_bank
// ----------------------------------------------------------------------------
// Purpose:
//   Bank of NUM_PORTS general-purpose I/O ports of WIDTH bits each, mapped
//   into the core's file-register address space beside the data RAM. Every
//   port owns a four-register block starting at BASE_ADDR + 4*p:
//     +0 PORT : write sets the output latch, read returns synchronised pins
//     +1 TRIS : per-bit direction, 1 = input (pin_oe = ~TRIS)
//     +2 IOCE : per-bit interrupt-on-change enable
//     +3 IOCF : per-bit sticky change flags; a write ANDs wdata into them
//   Pins pass through a two-flop synchroniser (S1, S2) and a history flop
//   (SP). Any enabled difference between S2 and SP sets the matching flag,
//   and irq is the OR of all flags in the bank.
//
// Ports:
//   clk      in   1                 single clock, rising edge
//   rst      in   1                 asynchronous reset, active low
//   addr     in   ADDR_W            register address
//   wr_en    in   1                 write strobe, one cycle per write
//   wdata    in   WIDTH             write data
//   rdata    out  WIDTH             combinational read data for addr
//   hit      out  1                 addr falls inside this bank's map
//   pin_in   in   NUM_PORTS*WIDTH   asynchronous pin levels, port p at [p*WIDTH +: WIDTH]
//   pin_out  out  NUM_PORTS*WIDTH   output latch values
//   pin_oe   out  NUM_PORTS*WIDTH   per-bit output enable (~TRIS)
//   irq      out  1                 OR of every IOCF bit
// ============================================================================
module io_port_bank #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned BASE_ADDR = 'h0C
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          addr,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       hit,
    input  logic [NUM_PORTS*WIDTH-1:0] pin_in,
    output logic [NUM_PORTS*WIDTH-1:0] pin_out,
    output logic [NUM_PORTS*WIDTH-1:0] pin_oe,
    output logic                       irq
);

    // ------------------------------------------------------------------------
    // Address map constants
    // ------------------------------------------------------------------------
    localparam int unsigned MAP_SIZE = 4 * NUM_PORTS;
    localparam int unsigned IDX_W    = ADDR_W - 1;

    localparam logic [ADDR_W:0] BASE_EXT = (ADDR_W + 1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] SPAN_EXT = (ADDR_W + 1)'(MAP_SIZE);

    typedef enum logic [1:0] {
        REG_PORT = 2'd0,
        REG_TRIS = 2'd1,
        REG_IOCE = 2'd2,
        REG_IOCF = 2'd3
    } reg_offset_e;

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (NUM_PORTS < 1 || NUM_PORTS > 8) begin : g_bad_num_ports
        $error("io_port_bank: NUM_PORTS must be in 1..8");
    end

    if (ADDR_W < 3) begin : g_bad_addr_w
        $error("io_port_bank: ADDR_W must be at least 3");
    end

    if (BASE_ADDR + MAP_SIZE - 1 > (2 ** ADDR_W) - 1) begin : g_bad_map
        $error("io_port_bank: register map exceeds the address space");
    end

    // ------------------------------------------------------------------------
    // Per-port state
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] latQ  [NUM_PORTS];
    logic [WIDTH-1:0] latD  [NUM_PORTS];
    logic [WIDTH-1:0] trisQ [NUM_PORTS];
    logic [WIDTH-1:0] trisD [NUM_PORTS];
    logic [WIDTH-1:0] ioceQ [NUM_PORTS];
    logic [WIDTH-1:0] ioceD [NUM_PORTS];
    logic [WIDTH-1:0] iocfQ [NUM_PORTS];
    logic [WIDTH-1:0] iocfD [NUM_PORTS];
    logic [WIDTH-1:0] s1Q   [NUM_PORTS];
    logic [WIDTH-1:0] s2Q   [NUM_PORTS];
    logic [WIDTH-1:0] spQ   [NUM_PORTS];

    logic [WIDTH-1:0] chgEvent [NUM_PORTS];

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    logic [ADDR_W:0]    relAddr;
    logic [IDX_W-1:0]   portIdx;
    reg_offset_e        regSel;
    logic [NUM_PORTS-1:0] portSel;
    logic               irqAny;

    // The subtraction is one bit wider than addr so that addresses below the
    // base wrap to a large value and fail the span test instead of aliasing.
    assign relAddr = {1'b0, addr} - BASE_EXT;
    assign portIdx = relAddr[ADDR_W:2];
    assign regSel  = reg_offset_e'(relAddr[1:0]);
    assign hit     = ({1'b0, addr} >= BASE_EXT) && (relAddr < SPAN_EXT);

    // One-hot port select, qualified by hit so that out-of-map addresses
    // never select a port even when their upper bits happen to match.
    always_comb begin
        portSel = '0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            portSel[p] = hit && (portIdx == IDX_W'(p));
        end
    end

    // ------------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------------
    // PORT reads the synchronised pin level rather than the latch so firmware
    // sees what is actually on the pad, including pins driven externally.
    always_comb begin
        rdata = '0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if (portSel[p]) begin
                case (regSel)
                    REG_PORT: rdata = s2Q[p];
                    REG_TRIS: rdata = trisQ[p];
                    REG_IOCE: rdata = ioceQ[p];
                    REG_IOCF: rdata = iocfQ[p];
                    default:  rdata = '0;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Change detection
    // ------------------------------------------------------------------------
    // Both rising and falling edges count; SP is S2 delayed by one clock, so
    // a single pin change produces a one-cycle event.
    always_comb begin
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            chgEvent[p] = (s2Q[p] ^ spQ[p]) & ioceQ[p];
        end
    end

    // ------------------------------------------------------------------------
    // Register next-state
    // ------------------------------------------------------------------------
    // The IOCF write term is applied first and the event term is ORed in
    // afterwards, so a clearing write that lands on the same edge as a new
    // change loses and the flag stays set.
    always_comb begin
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            latD[p]  = latQ[p];
            trisD[p] = trisQ[p];
            ioceD[p] = ioceQ[p];
            iocfD[p] = iocfQ[p];

            if (wr_en && portSel[p]) begin
                case (regSel)
                    REG_PORT: latD[p]  = wdata;
                    REG_TRIS: trisD[p] = wdata;
                    REG_IOCE: ioceD[p] = wdata;
                    REG_IOCF: iocfD[p] = iocfQ[p] & wdata;
                    default:  latD[p]  = latQ[p];
                endcase
            end

            iocfD[p] = iocfD[p] | chgEvent[p];
        end
    end

    // ------------------------------------------------------------------------
    // State registers and pin synchroniser
    // ------------------------------------------------------------------------
    // Reset leaves every pin as an input with interrupts disabled, so the
    // stale synchroniser contents after release cannot raise a flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                latQ[p]  <= '0;
                trisQ[p] <= '1;
                ioceQ[p] <= '0;
                iocfQ[p] <= '0;
                s1Q[p]   <= '0;
                s2Q[p]   <= '0;
                spQ[p]   <= '0;
            end
        end else begin
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                latQ[p]  <= latD[p];
                trisQ[p] <= trisD[p];
                ioceQ[p] <= ioceD[p];
                iocfQ[p] <= iocfD[p];
                s1Q[p]   <= pin_in[p*WIDTH +: WIDTH];
                s2Q[p]   <= s1Q[p];
                spQ[p]   <= s2Q[p];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Interrupt and pad outputs
    // ------------------------------------------------------------------------
    always_comb begin
        irqAny = 1'b0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            irqAny = irqAny | (|iocfQ[p]);
        end
    end

    assign irq = irqAny;

    // The latch drives pin_out unconditionally; the pad cell uses pin_oe to
    // decide whether it actually reaches the pin.
    for (genvar p = 0; p < int'(NUM_PORTS); p++) begin : g_pad
        assign pin_out[p*WIDTH +: WIDTH] = latQ[p];
        assign pin_oe[p*WIDTH +: WIDTH]  = ~trisQ[p];
    end

endmodule

// File: tb/tb_io_port_bank.sv
// ============================================================================
// tb_io_port_bank
// ----------------------------------------------------------------------------
// Self-checking bench for io_port_bank with two 8-bit ports at base 0x0C.
// Each scenario task pushes its expected values into a queue as it drives
// stimulus and pops them when the corresponding DUT output is sampled.
// ============================================================================
module tb_io_port_bank;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic [6:0]  addr    = '0;
    logic        wr_en   = 1'b0;
    logic [7:0]  wdata   = '0;
    logic [7:0]  rdata;
    logic        hit;
    logic [15:0] pin_in  = '0;
    logic [15:0] pin_out;
    logic [15:0] pin_oe;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [15:0] expQ [$];
    logic [15:0] expV;
    logic [15:0] obs;
    logic [7:0]  rd;

    io_port_bank #(
        .NUM_PORTS (2),
        .WIDTH     (8),
        .ADDR_W    (7),
        .BASE_ADDR ('h0C)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .wr_en   (wr_en),
        .wdata   (wdata),
        .rdata   (rdata),
        .hit     (hit),
        .pin_in  (pin_in),
        .pin_out (pin_out),
        .pin_oe  (pin_oe),
        .irq     (irq)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got timeout want finish");
        $fatal(1, "[TB] watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle write; returns 1 time unit after the edge that commits it.
    task automatic writeReg(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    // Combinational read; consumes 1 time unit.
    task automatic readReg(input logic [6:0] a, output logic [7:0] v);
        addr  = a;
        wr_en = 1'b0;
        #1;
        v = rdata;
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        pin_in = 16'($urandom);
        expQ.push_back(16'h0000);
        expQ.push_back(16'h0000);
        expQ.push_back(16'h0000);
        repeat (3) @(posedge clk);
        #2;
        obs = pin_out; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL reset_pin_out got %h want %h", obs, expV); end
        obs = pin_oe; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL reset_pin_oe got %h want %h", obs, expV); end
        obs = {15'h0, irq}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL reset_irq got %h want %h", obs, expV); end

        @(negedge clk);
        rst    = 1'b1;
        pin_in = '0;
        expQ.push_back(16'h00FF);
        expQ.push_back(16'h0000);
        expQ.push_back(16'h0000);
        expQ.push_back(16'h0000);
        repeat (3) stepEdge();
        readReg(7'h0D, rd); obs = {8'h0, rd}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL reset_tris0 got %h want %h", obs, expV); end
        readReg(7'h0F, rd); obs = {8'h0, rd}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL reset_iocf0 got %h want %h", obs, expV); end
        readReg(7'h13, rd); obs = {8'h0, rd}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL reset_iocf1 got %h want %h", obs, expV); end
        obs = pin_out; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL release_pin_out got %h want %h", obs, expV); end
    endtask

    task automatic test_output();
        expQ.push_back(16'h00FF);
        expQ.push_back(16'h0000);
        writeReg(7'h0D, 8'h00);
        obs = pin_oe; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL out_pin_oe got %h want %h", obs, expV); end
        obs = pin_out; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL out_lat_before got %h want %h", obs, expV); end

        expQ.push_back(16'h00A5);
        expQ.push_back(16'h00FF);
        writeReg(7'h0C, 8'hA5);
        obs = pin_out; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL out_pin_out got %h want %h", obs, expV); end
        obs = pin_oe; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL out_pin_oe_hold got %h want %h", obs, expV); end
    endtask

    task automatic test_readback();
        @(negedge clk);
        pin_in[15:8] = 8'h3C;
        expQ.push_back(16'h0000);
        expQ.push_back(16'h003C);
        expQ.push_back(16'h0000);
        stepEdge();
        readReg(7'h10, rd); obs = {8'h0, rd}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL readback_edge_k got %h want %h", obs, expV); end
        stepEdge();
        readReg(7'h10, rd); obs = {8'h0, rd}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL readback_edge_k1 got %h want %h", obs, expV); end
        repeat (2) stepEdge();
        readReg(7'h13, rd); obs = {8'h0, rd}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL readback_no_flag got %h want %h", obs, expV); end
    endtask

    task automatic test_ioc();
        writeReg(7'h12, 8'h01);
        @(negedge clk);
        pin_in[8] = 1'b1;
        expQ.push_back(16'h0000);
        expQ.push_back(16'h0000);
        expQ.push_back(16'h0001);
        expQ.push_back(16'h0001);
        stepEdge();
        stepEdge();
        readReg(7'h13, rd); obs = {8'h0, rd}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL ioc_flag_early got %h want %h", obs, expV); end
        obs = {15'h0, irq}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL ioc_irq_early got %h want %h", obs, expV); end
        stepEdge();
        readReg(7'h13, rd); obs = {8'h0, rd}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL ioc_flag got %h want %h", obs, expV); end
        obs = {15'h0, irq}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL ioc_irq got %h want %h", obs, expV); end

        expQ.push_back(16'h0000);
        expQ.push_back(16'h0000);
        writeReg(7'h13, 8'hFE);
        obs = {15'h0, irq}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL ioc_clear_irq got %h want %h", obs, expV); end
        readReg(7'h13, rd); obs = {8'h0, rd}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL ioc_clear_flag got %h want %h", obs, expV); end
    endtask

    task automatic test_collision();
        writeReg(7'h0E, 8'h05);
        @(negedge clk);
        pin_in[0] = 1'b1;
        expQ.push_back(16'h0001);
        expQ.push_back(16'h0001);
        repeat (3) stepEdge();
        readReg(7'h0F, rd); obs = {8'h0, rd}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL coll_pre_flag got %h want %h", obs, expV); end
        obs = {15'h0, irq}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL coll_pre_irq got %h want %h", obs, expV); end

        // Pin 2 changes before edge k; its event is live during edge k+2,
        // which is exactly the edge the clearing write commits on.
        @(negedge clk);
        pin_in[2] = 1'b1;
        expQ.push_back(16'h0004);
        expQ.push_back(16'h0001);
        expQ.push_back(16'h0004);
        stepEdge();
        stepEdge();
        writeReg(7'h0F, 8'h00);
        readReg(7'h0F, rd); obs = {8'h0, rd}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL coll_flag got %h want %h", obs, expV); end
        obs = {15'h0, irq}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL coll_irq got %h want %h", obs, expV); end
        stepEdge();
        readReg(7'h0F, rd); obs = {8'h0, rd}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL coll_flag_hold got %h want %h", obs, expV); end
    endtask

    task automatic test_decode_reset();
        @(negedge clk);
        addr  = 7'h14;
        wdata = 8'hFF;
        wr_en = 1'b1;
        expQ.push_back(16'h0000);
        expQ.push_back(16'h0000);
        #1;
        obs = {15'h0, hit}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL dec_hit_0x14 got %h want %h", obs, expV); end
        obs = {8'h0, rdata}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL dec_rdata_0x14 got %h want %h", obs, expV); end
        @(posedge clk);
        #1;
        wr_en = 1'b0;

        expQ.push_back(16'h00A5);
        expQ.push_back(16'h00FF);
        expQ.push_back(16'h00FF);
        expQ.push_back(16'h0000);
        expQ.push_back(16'h0001);
        obs = pin_out; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL dec_pin_out got %h want %h", obs, expV); end
        obs = pin_oe; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL dec_pin_oe got %h want %h", obs, expV); end
        readReg(7'h11, rd); obs = {8'h0, rd}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL dec_tris1 got %h want %h", obs, expV); end
        addr = 7'h0B;
        #1;
        obs = {15'h0, hit}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL dec_hit_0x0B got %h want %h", obs, expV); end
        addr = 7'h13;
        #1;
        obs = {15'h0, hit}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL dec_hit_0x13 got %h want %h", obs, expV); end

        // Asynchronous reset pulsed well away from any clock edge.
        @(posedge clk);
        #3;
        expQ.push_back(16'h0001);
        expQ.push_back(16'h0000);
        expQ.push_back(16'h0000);
        expQ.push_back(16'h0000);
        expQ.push_back(16'h00FF);
        obs = {15'h0, irq}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL arst_irq_before got %h want %h", obs, expV); end
        rst = 1'b0;
        #1;
        obs = pin_out; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL arst_pin_out got %h want %h", obs, expV); end
        obs = pin_oe; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL arst_pin_oe got %h want %h", obs, expV); end
        obs = {15'h0, irq}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL arst_irq got %h want %h", obs, expV); end
        readReg(7'h0D, rd); obs = {8'h0, rd}; expV = expQ.pop_front(); checks++;
        if (obs !== expV) begin errors++; $display("[TB] FAIL arst_tris0 got %h want %h", obs, expV); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        $display("[TB] io_port_bank bench start");
        test_reset();
        test_output();
        test_readback();
        test_ioc();
        test_collision();
        test_decode_reset();
        repeat (2) @(posedge clk);
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain got %0d want 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
